fb_port_arbiter: RTL

Arbitrates the single port of the image frame-buffer RAM between the display fetch path and an image loader. Sits between `vga_controller` and the frame-buffer RAM in the 25 MHz pixel domain: it converts `curr_x`/`curr_y` into 2x-upscaled RAM reads, delivers registered 12-bit pixels with matching delayed syncs, and grants loader writes only in slots the display does not need.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_port_arbiter_if.sv | 32 +++
 rtl/fb_addr_gen.sv | 65 ++++++
 rtl/fb_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
// fb_pkg: definitions shared by the frame-buffer port arbiter, its address
// generator and the code that instantiates them.
//   IMG_W_DEF / IMG_H_DEF : default stored image size (words x lines)
//   H_ACTIVE / V_ACTIVE   : visible VGA area in pixels
//   rgb444_t              : one 12-bit RGB444 pixel
//   pipe_state_t          : pixel pipeline control states
package fb_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;

  typedef logic [11:0] rgb444_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } pipe_state_t;

  // The display fetches one word per column pair, always on the even column.
  function automatic logic is_display_slot(input logic video_on, input logic col_lsb);
    return video_on & ~col_lsb;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
`timescale 1ns/1ps
// fb_port_arbiter_if: loader write channel into the frame-buffer arbiter.
//   wr_valid : loader has a write pending
//   wr_ready : arbiter grants the write this cycle
//   wr_addr  : word address of the write
//   wr_data  : RGB444 word to store
// master = image loader, slave = fb_port_arbiter.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/fb_addr_gen.sv
`timescale 1ns/1ps
// fb_addr_gen: 2x-downscaled frame-buffer read address plus the registered
// RAM address.
//   clk, reset : pixel clock, asynchronous active-high reset
//   x_half     : curr_x >> 1 (stored-image column)
//   y_half     : curr_y >> 1 (stored-image line)
//   load_rd    : display slot, register the computed read address
//   load_wr    : accepted in-range write, register wr_addr
//   wr_addr    : loader write address
//   addr_reg   : registered RAM address
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        x_half,
  input  logic [8:0]        y_half,
  input  logic              load_rd,
  input  logic              load_wr,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] addr_reg
);

  localparam logic [ADDR_W-1:0] IMG_W_V = ADDR_W'(IMG_W);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] pp [ADDR_W];
  logic [ADDR_W-1:0] rd_addr_next;

  assign y_ext = ADDR_W'(y_half);

  // y*IMG_W as a sum of shifted copies of y, one per set bit of IMG_W.
  // Everything is kept at ADDR_W bits so overflow wraps with the RAM width.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_pp
      if (IMG_W_V[gi]) begin : g_on
        assign pp[gi] = y_ext << gi;
      end else begin : g_off
        assign pp[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    rd_addr_next = ADDR_W'(x_half);
    for (int i = 0; i < ADDR_W; i++) begin
      rd_addr_next = rd_addr_next + pp[i];
    end
  end

  // The address is held on idle slots; ram_en qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
    end else if (load_rd) begin
      addr_reg <= rd_addr_next;
    end else if (load_wr) begin
      addr_reg <= wr_addr;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
`timescale 1ns/1ps
// fb_port_arbiter: shares the single frame-buffer RAM port between the VGA
// display fetch (2x upscaled reads) and an image loader (writes in slots the
// display does not use).
//   clk, reset            : 25 MHz pixel clock, asynchronous active-high reset
//   curr_x, curr_y        : raster position from vga_controller
//   video_on              : visible-area flag
//   hsync_in, vsync_in    : raw syncs
//   hsync, vsync          : syncs delayed 3 cycles to line up with pixel_rgb
//   pixel_rgb             : registered pixel, 0 while blanked
//   wr_vblank_only        : restrict loader writes to lines >= V_ACTIVE
//   wr                    : loader write channel (valid/ready/addr/data)
//   ram_en/we/addr/wdata  : registered RAM port controls
//   ram_rdata             : RAM read data, one cycle after the address
//   wr_count              : committed writes, saturating
//   wr_drop               : sticky, set by a write beyond the image
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        curr_x,
  input  logic [9:0]        curr_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              hsync,
  output logic              vsync,
  output logic [DATA_W-1:0] pixel_rgb,
  input  logic              wr_vblank_only,
  fb_port_arbiter_if.slave  wr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0] WR_LIMIT    = (ADDR_W+1)'(IMG_W * IMG_H);
  localparam logic [9:0]      VBLANK_LINE = 10'(V_ACTIVE);

  // Slot classification and write handshake
  logic display_slot;
  logic writable;
  logic xfer;
  logic in_range;
  logic wr_ok;
  logic wr_bad;

  assign display_slot = is_display_slot(video_on, curr_x[0]);
  assign writable     = ~display_slot & (~wr_vblank_only | (curr_y >= VBLANK_LINE));
  assign wr.wr_ready  = writable & ~reset;
  assign xfer         = wr.wr_valid & wr.wr_ready;
  assign in_range     = {1'b0, wr.wr_addr} < WR_LIMIT;
  assign wr_ok        = xfer & in_range;
  assign wr_bad       = xfer & ~in_range;

  // S1: RAM controls, write bookkeeping and the tags riding with the read
  logic              ram_en_reg;
  logic              ram_we_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic [ADDR_W:0]   wr_count_reg;
  logic [ADDR_W:0]   wr_count_next;
  logic              wr_drop_reg;
  logic              vid_s1_reg, odd_s1_reg, hs_s1_reg, vs_s1_reg;
  // S2: tags alongside the RAM read
  logic              vid_s2_reg, odd_s2_reg, hs_s2_reg, vs_s2_reg;
  // S3: outputs
  logic              hsync_reg, vsync_reg;
  logic [DATA_W-1:0] pixel_reg;
  logic [DATA_W-1:0] hold_reg;
  pipe_state_t       state_reg;
  logic              fill_cnt_reg;

  fb_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .x_half   (curr_x[9:1]),
    .y_half   (curr_y[9:1]),
    .load_rd  (display_slot),
    .load_wr  (wr_ok),
    .wr_addr  (wr.wr_addr),
    .addr_reg (ram_addr)
  );

  // Saturate at all-ones rather than wrapping back to zero.
  assign wr_count_next = (wr_ok && !(&wr_count_reg))
                       ? wr_count_reg + (ADDR_W+1)'(1)
                       : wr_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_wdata_reg <= '0;
      wr_count_reg  <= '0;
      wr_drop_reg   <= 1'b0;
      vid_s1_reg    <= 1'b0;
      odd_s1_reg    <= 1'b0;
      hs_s1_reg     <= 1'b0;
      vs_s1_reg     <= 1'b0;
      vid_s2_reg    <= 1'b0;
      odd_s2_reg    <= 1'b0;
      hs_s2_reg     <= 1'b0;
      vs_s2_reg     <= 1'b0;
      hsync_reg     <= 1'b0;
      vsync_reg     <= 1'b0;
    end else begin
      ram_en_reg   <= display_slot | wr_ok;
      ram_we_reg   <= wr_ok;
      if (wr_ok) begin
        ram_wdata_reg <= wr.wr_data;
      end
      wr_count_reg <= wr_count_next;
      if (wr_bad) begin
        wr_drop_reg <= 1'b1;
      end
      vid_s1_reg <= video_on;
      odd_s1_reg <= curr_x[0];
      hs_s1_reg  <= hsync_in;
      vs_s1_reg  <= vsync_in;
      vid_s2_reg <= vid_s1_reg;
      odd_s2_reg <= odd_s1_reg;
      hs_s2_reg  <= hs_s1_reg;
      vs_s2_reg  <= vs_s1_reg;
      hsync_reg  <= hs_s2_reg;
      vsync_reg  <= vs_s2_reg;
    end
  end

  // Pipeline control and S3 pixel register. FILL blanks the output for the
  // two cycles it takes real tags to reach S2 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FILL;
      fill_cnt_reg <= 1'b0;
      pixel_reg    <= '0;
      hold_reg     <= '0;
    end else begin
      unique case (state_reg)
        FILL: begin
          pixel_reg    <= '0;
          fill_cnt_reg <= ~fill_cnt_reg;
          if (fill_cnt_reg) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!vid_s2_reg) begin
            pixel_reg <= '0;
          end else if (!odd_s2_reg) begin
            // Even column: fresh word, kept for the odd neighbour.
            hold_reg  <= ram_rdata;
            pixel_reg <= ram_rdata;
          end else begin
            pixel_reg <= hold_reg;
          end
        end
      endcase
    end
  end

  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_wdata = ram_wdata_reg;
  assign wr_count  = wr_count_reg;
  assign wr_drop   = wr_drop_reg;
  assign hsync     = hsync_reg;
  assign vsync     = vsync_reg;
  assign pixel_rgb = pixel_reg;

endmodule
